// File: rtl/sdram_cmd_exec_if.sv
// rtl/sdram_cmd_exec_if.sv - command handshake between sdram_ctrl and the command executor
interface sdram_cmd_exec_if #(
    parameter int DW  = 16,
    parameter int RAW = 12
);
    logic              cmd_valid;
    logic [3:0]        cmd_type;
    logic [RAW-1:0]    cmd_addr;
    logic [1:0]        cmd_ba;
    logic [DW-1:0]     cmd_data;
    logic [DW/8-1:0]   cmd_dqm;
    logic              cmd_done;
    logic              cmd_early_done;
    logic              cmd_wip;

    modport master (
        output cmd_valid, cmd_type, cmd_addr, cmd_ba, cmd_data, cmd_dqm,
        input  cmd_done, cmd_early_done, cmd_wip
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_addr, cmd_ba, cmd_data, cmd_dqm,
        output cmd_done, cmd_early_done, cmd_wip
    );
endinterface

// File: rtl/sdram_cmd_exec.sv
// rtl/sdram_cmd_exec.sv - SDRAM command executor: registered pins, per-command timing, tWR hold
// A PRECHARGE that arrives inside the write-recovery window is parked in WR_HOLD until tWR expires.
module sdram_cmd_exec #(
    parameter int CLK_FREQ = 100,
    parameter int DW       = 16,
    parameter int RAW      = 12,
    parameter int tRCD     = 20,
    parameter int tRP      = 20,
    parameter int tRFC     = 70,
    parameter int tWR      = 15
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    sdram_cmd_exec_if.slave cmd,
    output logic            o_sdram_cs_n,
    output logic            o_sdram_ras_n,
    output logic            o_sdram_cas_n,
    output logic            o_sdram_we_n,
    output logic [RAW-1:0]  o_sdram_addr,
    output logic [1:0]      o_sdram_ba,
    output logic [DW/8-1:0] o_sdram_dqm,
    output logic [DW-1:0]   o_sdram_dq_out,
    output logic            o_sdram_dq_oe
);
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;

    function automatic logic [7:0] ns_to_cyc(input int t_ns);
        int c;
        c = (t_ns * CLK_FREQ + 999) / 1000;
        if (c < 1) c = 1;
        return c[7:0];
    endfunction

    localparam logic [7:0] C_RCD = ns_to_cyc(tRCD);
    localparam logic [7:0] C_RP  = ns_to_cyc(tRP);
    localparam logic [7:0] C_RFC = ns_to_cyc(tRFC);
    localparam logic [7:0] C_WR  = ns_to_cyc(tWR);
    localparam logic [7:0] C_MRD = 8'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_WR_HOLD} state_t;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic [7:0]       r_twr;
    logic             r_done, w_done_nxt;
    logic             r_done_short, w_done_short_nxt;
    logic [3:0]       r_cmd, w_cmd_nxt;
    logic [RAW-1:0]   r_addr, w_addr_nxt;
    logic [1:0]       r_ba, w_ba_nxt;
    logic [DW/8-1:0]  r_dqm, w_dqm_nxt;
    logic [DW-1:0]    r_dq_out, w_dq_out_nxt;
    logic             r_dq_oe, w_dq_oe_nxt;
    logic [RAW-1:0]   r_pre_addr;
    logic [1:0]       r_pre_ba;
    logic             w_pre_latch;
    logic             w_accept;
    logic             w_wip;
    logic [7:0]       w_lat;

    assign w_wip    = (r_state != ST_IDLE);
    assign w_accept = cmd.cmd_valid & ~w_wip;

    always_comb begin
        case (cmd.cmd_type)
            CMD_ACT: w_lat = C_RCD;
            CMD_PRE: w_lat = C_RP;
            CMD_REF: w_lat = C_RFC;
            CMD_LMR: w_lat = C_MRD;
            default: w_lat = 8'd1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 8'd0;
            r_done       <= 1'b0;
            r_done_short <= 1'b0;
            r_cmd        <= CMD_NOP;
            r_addr       <= '0;
            r_ba         <= '0;
            r_dqm        <= '1;
            r_dq_out     <= '0;
            r_dq_oe      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_done       <= w_done_nxt;
            r_done_short <= w_done_short_nxt;
            r_cmd        <= w_cmd_nxt;
            r_addr       <= w_addr_nxt;
            r_ba         <= w_ba_nxt;
            r_dqm        <= w_dqm_nxt;
            r_dq_out     <= w_dq_out_nxt;
            r_dq_oe      <= w_dq_oe_nxt;
        end
    end

    // Write recovery runs independently of the FSM so any later PRECHARGE sees it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_twr <= 8'd0;
        end else if (w_accept && cmd.cmd_type == CMD_WRITE) begin
            r_twr <= C_WR;
        end else if (r_twr != 8'd0) begin
            r_twr <= r_twr - 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre_addr <= '0;
            r_pre_ba   <= '0;
        end else if (w_pre_latch) begin
            r_pre_addr <= cmd.cmd_addr;
            r_pre_ba   <= cmd.cmd_ba;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_done_nxt       = 1'b0;
        w_done_short_nxt = 1'b0;
        w_cmd_nxt        = CMD_NOP;
        w_addr_nxt       = r_addr;
        w_ba_nxt         = r_ba;
        w_dqm_nxt        = '1;
        w_dq_out_nxt     = r_dq_out;
        w_dq_oe_nxt      = 1'b0;
        w_pre_latch      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (cmd.cmd_type == CMD_PRE && r_twr != 8'd0) begin
                        w_pre_latch = 1'b1;
                        w_state_nxt = ST_WR_HOLD;
                    end else begin
                        w_cmd_nxt  = cmd.cmd_type;
                        w_addr_nxt = cmd.cmd_addr;
                        w_ba_nxt   = cmd.cmd_ba;
                        if (cmd.cmd_type == CMD_READ || cmd.cmd_type == CMD_WRITE) begin
                            w_dqm_nxt = cmd.cmd_dqm;
                        end
                        if (cmd.cmd_type == CMD_WRITE) begin
                            w_dq_oe_nxt  = 1'b1;
                            w_dq_out_nxt = cmd.cmd_data;
                        end
                        if (w_lat > 8'd1) begin
                            w_state_nxt = ST_BUSY;
                            w_cnt_nxt   = w_lat - 8'd1;
                        end else begin
                            w_done_nxt       = 1'b1;
                            w_done_short_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt <= 8'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_WR_HOLD: begin
                // Full cRP from the delayed pin cycle: the hold already consumed the accept cycle.
                if (r_twr == 8'd0) begin
                    w_cmd_nxt   = CMD_PRE;
                    w_addr_nxt  = r_pre_addr;
                    w_ba_nxt    = r_pre_ba;
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = C_RP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign cmd.cmd_done       = r_done;
    assign cmd.cmd_early_done = (r_state == ST_BUSY && r_cnt == 8'd1) | (r_done & r_done_short);
    assign cmd.cmd_wip        = w_wip;

    assign {o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n} = r_cmd;
    assign o_sdram_addr   = r_addr;
    assign o_sdram_ba     = r_ba;
    assign o_sdram_dqm    = r_dqm;
    assign o_sdram_dq_out = r_dq_out;
    assign o_sdram_dq_oe  = r_dq_oe;

    a_no_cmd_while_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(cmd.cmd_valid && w_wip));
endmodule

// File: tb/tb_sdram_cmd_exec.sv
// tb/tb_sdram_cmd_exec.sv - randomized and directed bench for sdram_cmd_exec against a cycle-schedule model
module tb_sdram_cmd_exec;
    localparam int DW = 16;
    localparam int RAW = 12;
    localparam int C_RCD = 2, C_RP = 2, C_RFC = 7, C_WR = 2, C_MRD = 2;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000;
    localparam int LOGN = 8192;

    typedef struct {
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic [1:0]  ba;
        logic [1:0]  dqm;
        logic        oe;
        logic [15:0] dq;
    } pin_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic [1:0]  ba;
        logic [1:0]  dqm;
        logic [15:0] dq;
        logic        oe;
        logic        done;
        logic        early;
        logic        wip;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_cmd_exec_if #(.DW(DW), .RAW(RAW)) bus ();

    logic            cs_n, ras_n, cas_n, we_n;
    logic [RAW-1:0]  addr;
    logic [1:0]      ba;
    logic [DW/8-1:0] dqm;
    logic [DW-1:0]   dq_out;
    logic            dq_oe;

    sdram_cmd_exec #(
        .CLK_FREQ(100), .DW(DW), .RAW(RAW),
        .tRCD(20), .tRP(20), .tRFC(70), .tWR(15)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .cmd            (bus),
        .o_sdram_cs_n   (cs_n),
        .o_sdram_ras_n  (ras_n),
        .o_sdram_cas_n  (cas_n),
        .o_sdram_we_n   (we_n),
        .o_sdram_addr   (addr),
        .o_sdram_ba     (ba),
        .o_sdram_dqm    (dqm),
        .o_sdram_dq_out (dq_out),
        .o_sdram_dq_oe  (dq_oe)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    // Model: every accepted command becomes a set of scheduled events by cycle number.
    pin_t exp_pin  [int];
    bit   exp_done [int];
    bit   exp_early[int];
    bit   exp_wip  [int];
    int   last_wr_pin = -100;
    int   free_at = 0;
    int   m_T, m_pin, m_done;
    logic [11:0] held_addr = '0;
    logic [1:0]  held_ba = '0;
    snap_t log_s [LOGN];

    function automatic int latency(input logic [3:0] t);
        case (t)
            ACT:     return C_RCD;
            PRE:     return C_RP;
            REF:     return C_RFC;
            LMR:     return C_MRD;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        exp_pin.delete();
        exp_done.delete();
        exp_early.delete();
        exp_wip.delete();
        last_wr_pin = -100;
        free_at = 0;
        held_addr = '0;
        held_ba = '0;
    endtask

    task automatic model_accept(input int t, input logic [3:0] ty, input logic [11:0] a,
                                input logic [1:0] b, input logic [15:0] d, input logic [1:0] m);
        int l, pin, done, early;
        pin_t p;
        bit delayed;
        l = latency(ty);
        pin = t + 1;
        delayed = 1'b0;
        if (ty == PRE && last_wr_pin + C_WR + 1 > t + 1) begin
            pin = last_wr_pin + C_WR + 1;
            delayed = 1'b1;
        end
        done = delayed ? pin + C_RP : t + l;
        early = (l == 1 && !delayed) ? done : done - 1;
        p.cmd = ty; p.addr = a; p.ba = b;
        p.dqm = (ty == RD || ty == WR) ? m : 2'b11;
        p.oe = (ty == WR);
        p.dq = d;
        exp_pin[pin] = p;
        exp_done[done] = 1'b1;
        exp_early[early] = 1'b1;
        for (int c = t + 1; c < done; c++) exp_wip[c] = 1'b1;
        if (ty == WR) last_wr_pin = pin;
        free_at = done;
        m_T = t; m_pin = pin; m_done = done;
    endtask

    // Caller is always just after a rising edge.
    task automatic issue(input logic [3:0] ty, input logic [11:0] a, input logic [1:0] b,
                         input logic [15:0] d, input logic [1:0] m);
        while (cyc < free_at) begin @(posedge clk); #1; end
        bus.cmd_valid = 1'b1;
        bus.cmd_type = ty;
        bus.cmd_addr = a;
        bus.cmd_ba = b;
        bus.cmd_data = d;
        bus.cmd_dqm = m;
        model_accept(cyc, ty, a, b, d, m);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            pin_t e;
            if (exp_pin.exists(cyc)) begin
                e = exp_pin[cyc];
                held_addr = e.addr;
                held_ba = e.ba;
            end else begin
                e.cmd = NOP; e.addr = held_addr; e.ba = held_ba;
                e.dqm = 2'b11; e.oe = 1'b0; e.dq = '0;
            end
            if (cyc < LOGN) log_s[cyc] = {{cs_n, ras_n, cas_n, we_n}, addr, ba, dqm, dq_out,
                                          dq_oe, bus.cmd_done, bus.cmd_early_done, bus.cmd_wip};
            check("pin_cmd", {28'd0, cs_n, ras_n, cas_n, we_n}, {28'd0, e.cmd});
            check("pin_addr", {20'd0, addr}, {20'd0, e.addr});
            check("pin_ba", {30'd0, ba}, {30'd0, e.ba});
            check("pin_dqm", {30'd0, dqm}, {30'd0, e.dqm});
            check("pin_dq_oe", {31'd0, dq_oe}, {31'd0, e.oe});
            if (e.oe) check("pin_dq_out", {16'd0, dq_out}, {16'd0, e.dq});
            check("cmd_done", {31'd0, bus.cmd_done}, {31'd0, exp_done.exists(cyc)});
            check("cmd_early_done", {31'd0, bus.cmd_early_done}, {31'd0, exp_early.exists(cyc)});
            check("cmd_wip", {31'd0, bus.cmd_wip}, {31'd0, exp_wip.exists(cyc)});
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        logic [3:0] ty;
        bus.cmd_valid = 1'b0;
        bus.cmd_type = NOP;
        bus.cmd_addr = '0;
        bus.cmd_ba = '0;
        bus.cmd_data = '0;
        bus.cmd_dqm = '0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Reset mid-REFRESH, counter at 4.
        issue(REF, 12'h055, 2'd1, 16'h0, 2'b00);
        t0 = m_T;
        while (cyc < t0 + 3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_pin_cmd", {28'd0, cs_n, ras_n, cas_n, we_n}, 32'h7);
        check("rst_dqm", {30'd0, dqm}, 32'h3);
        check("rst_addr_ba", {18'd0, addr, ba}, 32'h0);
        check("rst_wip_done", {30'd0, bus.cmd_wip, bus.cmd_done}, 32'h0);
        check("rst_dq_oe", {31'd0, dq_oe}, 32'h0);
        @(negedge clk); @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ACTIVE then READ in its done cycle.
        issue(ACT, 12'h123, 2'd2, 16'h0, 2'b00);
        t0 = m_T;
        issue(RD, 12'h045, 2'd2, 16'h0, 2'b10);
        idle(2);
        check("act_pin", {16'd0, log_s[t0+1].cmd, log_s[t0+1].addr}, {16'd0, 4'b0011, 12'h123});
        check("act_ba", {30'd0, log_s[t0+1].ba}, 32'd2);
        check("act_wip_early", {30'd0, log_s[t0+1].wip, log_s[t0+1].early}, 32'h3);
        check("act_done", {31'd0, log_s[t0+2].done}, 32'h1);
        check("act_rd_pin", {28'd0, log_s[t0+3].cmd}, {28'd0, RD});

        // Four back-to-back READs.
        t0 = cyc;
        for (int i = 0; i < 4; i++) issue(RD, 12'(i * 8), 2'd0, 16'h0, 2'b00);
        idle(2);
        for (int i = 1; i <= 4; i++) begin
            check("b2b_rd_pin", {28'd0, log_s[t0+i].cmd}, {28'd0, RD});
            check("b2b_rd_done_wip", {30'd0, log_s[t0+i].done, log_s[t0+i].wip}, 32'h2);
        end

        // WRITE then PRECHARGE inside the recovery window.
        issue(WR, 12'h010, 2'd1, 16'hBEEF, 2'b01);
        t0 = m_T;
        issue(PRE, 12'h400, 2'd1, 16'h0, 2'b00);
        check("model_pre_pin", m_pin, t0 + 4);
        check("model_pre_done", m_done, t0 + 6);
        idle(7);
        check("wr_pin", {11'd0, log_s[t0+1].cmd, log_s[t0+1].oe, log_s[t0+1].dq},
                        {11'd0, WR, 1'b1, 16'hBEEF});
        check("wr_dqm", {30'd0, log_s[t0+1].dqm}, 32'h1);
        check("hold_nop", {24'd0, log_s[t0+2].cmd, log_s[t0+3].cmd}, {24'd0, NOP, NOP});
        check("hold_wip", {28'd0, log_s[t0+2].wip, log_s[t0+3].wip, log_s[t0+4].wip, log_s[t0+5].wip}, 32'hF);
        check("pre_pin", {16'd0, log_s[t0+4].cmd, log_s[t0+4].addr}, {16'd0, PRE, 12'h400});
        check("pre_done", {30'd0, log_s[t0+5].done, log_s[t0+6].done}, 32'h1);

        // REFRESH timing.
        issue(REF, 12'h000, 2'd0, 16'h0, 2'b00);
        t0 = m_T;
        idle(9);
        check("ref_pin", {28'd0, log_s[t0+1].cmd}, {28'd0, REF});
        check("ref_early", {30'd0, log_s[t0+5].early, log_s[t0+6].early}, 32'h1);
        check("ref_done", {30'd0, log_s[t0+6].done, log_s[t0+7].done}, 32'h1);

        // Load mode register.
        issue(LMR, 12'h023, 2'd0, 16'h0, 2'b00);
        t0 = m_T;
        idle(4);
        check("lmr_pin", {16'd0, log_s[t0+1].cmd, log_s[t0+1].addr}, {16'd0, LMR, 12'h023});
        check("lmr_done", {30'd0, log_s[t0+1].done, log_s[t0+2].done}, 32'h1);

        // Randomized command stream.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       ty = NOP;
                1:       ty = ACT;
                2, 3:    ty = RD;
                4, 5:    ty = WR;
                6, 7:    ty = PRE;
                8:       ty = REF;
                default: ty = LMR;
            endcase
            issue(ty, 12'($urandom), 2'($urandom), 16'($urandom), 2'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        while (cyc < free_at + 3) begin @(posedge clk); #1; end
        @(negedge clk); #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
